// File: rtl/sram_controller_if.sv
// Memory-stage side of the SRAM controller: load/store request, data and the
// pipeline freeze handshake.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low half, then
// high half), each held for SRAM_WAIT cycles, and freezes the pipeline meanwhile.
module sram_controller #(
    parameter int          SRAM_WAIT = 2,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_ADDR,
    output logic             SRAM_WE_N,
    output logic             SRAM_OE_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SRAM_WAIT - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] idx_p0;
    logic [31:0] wdata_p0;
    logic        wr_op_p0;
    logic [31:0] rdata;
    logic        dq_oe;
    logic        req;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign req    = bus.wr_en | bus.rd_en;
    assign offset = bus.address - BASE_ADDR;
    // Only 17 bits of word index fit the 18-bit half-word SRAM address.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    assign SRAM_DQ   = dq_oe ? ((state == HIGH) ? wdata_p0[31:16] : wdata_p0[15:0]) : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign bus.read_data = rdata;
    assign bus.ready     = (state == DONE) || ((state == IDLE) && !req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_p0    <= '0;
            wdata_p0  <= '0;
            wr_op_p0  <= 1'b0;
            rdata     <= '0;
            dq_oe     <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // A simultaneous load and store is treated as a store.
                        state     <= LOW;
                        cnt       <= '0;
                        idx_p0    <= offset[18:2];
                        wdata_p0  <= bus.write_data;
                        wr_op_p0  <= bus.wr_en;
                        SRAM_ADDR <= {offset[18:2], 1'b0};
                        SRAM_WE_N <= !bus.wr_en;
                        SRAM_OE_N <= bus.wr_en;
                        dq_oe     <= bus.wr_en;
                    end
                end
                LOW: begin
                    if (cnt == WAIT_LAST) begin
                        cnt       <= '0;
                        state     <= HIGH;
                        SRAM_ADDR <= {idx_p0, 1'b1};
                        if (!wr_op_p0) rdata[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt == WAIT_LAST) begin
                        cnt       <= '0;
                        state     <= DONE;
                        SRAM_ADDR <= '0;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!wr_op_p0) rdata[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: stimulus queues expected SRAM bus beats
// and completions; negedge monitors pop and compare them.
`timescale 1ns/1ps
module tb_sram_controller;
    localparam int W0 = 2;
    localparam int W1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_controller_if bus0();
    sram_controller_if bus1();

    wire  [15:0] dq0, dq1;
    logic [17:0] addr0, addr1;
    logic        we0, oe0, ce0, ub0, lb0;
    logic        we1, oe1, ce1, ub1, lb1;

    sram_controller #(.SRAM_WAIT(W0), .BASE_ADDR(32'd1024)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_controller #(.SRAM_WAIT(W1), .BASE_ADDR(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // Asynchronous SRAM models: drive on read, capture on write.
    logic [15:0] mem0 [0:262143] = '{default: 16'h0};
    logic [15:0] mem1 [0:262143] = '{default: 16'h0};
    assign dq0 = (!oe0 && we0) ? mem0[addr0] : 16'hzzzz;
    assign dq1 = (!oe1 && we1) ? mem1[addr1] : 16'hzzzz;
    always @(posedge clk) if (!we0) mem0[addr0] <= dq0;
    always @(posedge clk) if (!we1) mem1[addr1] <= dq1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        chk_dq;
        logic        we_n;
        logic        oe_n;
        logic [17:0] addr;
        logic [15:0] dq;
    } beat_t;

    typedef struct {
        int          done_cyc;
        logic [31:0] rdata;
    } comp_t;

    beat_t beat_q[$];
    comp_t comp0_q[$];
    comp_t comp1_q[$];

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_txn(bit wr, logic [17:0] a, logic [15:0] lo, logic [15:0] hi,
                                     int nbeats, int done_cyc, logic [31:0] rdata);
        beat_t b;
        comp_t c;
        b = '{1'b0, 1'b1, 1'b1, 18'd0, 16'd0};
        beat_q.push_back(b);
        for (int i = 1; i < nbeats; i++) begin
            b.chk_dq = 1'b1;
            b.we_n   = !wr;
            b.oe_n   = wr;
            b.addr   = (i <= W0) ? a : a + 18'd1;
            b.dq     = (i <= W0) ? lo : hi;
            beat_q.push_back(b);
        end
        c.done_cyc = done_cyc;
        c.rdata    = rdata;
        comp0_q.push_back(c);
    endfunction

    // Monitors
    logic  busy0 = 1'b0;
    logic  busy1 = 1'b0;
    beat_t mb0;
    comp_t mc0, mc1;

    always @(negedge clk) begin
        if (busy0 && bus0.ready) begin
            busy0 = 1'b0;
            if (comp0_q.size() == 0) chk("dut0_extra_done", comp0_q.size(), 1);
            else begin
                mc0 = comp0_q.pop_front();
                chk("dut0_done_cycle", cyc, mc0.done_cyc);
                chk("dut0_read_data", bus0.read_data, mc0.rdata);
                chk("dut0_idle_bus", {we0, oe0, addr0}, {1'b1, 1'b1, 18'd0});
            end
        end else if (busy0 || (!rst && !bus0.ready)) begin
            busy0 = 1'b1;
            if (beat_q.size() == 0) chk("dut0_extra_beat", beat_q.size(), 1);
            else begin
                mb0 = beat_q.pop_front();
                chk("dut0_bus", {we0, oe0, addr0, (mb0.chk_dq ? dq0 : mb0.dq)},
                    {mb0.we_n, mb0.oe_n, mb0.addr, mb0.dq});
            end
        end
    end

    always @(negedge clk) begin
        if (busy1 && bus1.ready) begin
            busy1 = 1'b0;
            if (comp1_q.size() == 0) chk("dut1_extra_done", comp1_q.size(), 1);
            else begin
                mc1 = comp1_q.pop_front();
                chk("dut1_done_cycle", cyc, mc1.done_cyc);
                chk("dut1_read_data", bus1.read_data, mc1.rdata);
                chk("dut1_idle_bus", {we1, oe1, addr1}, {1'b1, 1'b1, 18'd0});
            end
        end else if (!rst && !bus1.ready) begin
            busy1 = 1'b1;
        end
    end

    task automatic next(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One dut0 transaction; request dropped and address/data scrambled after cycle 0.
    task automatic issue0(bit wr, bit rd, logic [31:0] addr, logic [31:0] data,
                          logic [17:0] sa, logic [15:0] lo, logic [15:0] hi, logic [31:0] rdata);
        int c0;
        c0 = cyc;
        bus0.wr_en = wr;
        bus0.rd_en = rd;
        bus0.address = addr;
        bus0.write_data = data;
        push_txn(wr, sa, lo, hi, 2 * W0 + 1, c0 + 2 * W0 + 1, rdata);
        next(1);
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
        bus0.address = 32'hFFFF_FFFF;
        bus0.write_data = 32'h0;
        next(2 * W0 + 1);
    endtask

    task automatic issue1(bit wr, logic [31:0] addr, logic [31:0] data, logic [31:0] rdata);
        comp_t c;
        c.done_cyc = cyc + 2 * W1 + 1;
        c.rdata = rdata;
        comp1_q.push_back(c);
        bus1.wr_en = wr;
        bus1.rd_en = !wr;
        bus1.address = addr;
        bus1.write_data = data;
        next(1);
        bus1.wr_en = 1'b0;
        bus1.rd_en = 1'b0;
        bus1.address = 32'h0;
        bus1.write_data = 32'h0;
        next(2 * W1 + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.address = '0; bus0.write_data = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.address = '0; bus1.write_data = '0;
        rst = 1'b1;
        next(1);

        // Reset state, ready still follows the request while in reset
        bus0.rd_en = 1'b1;
        #1 chk("rst_ready_req", bus0.ready, 0);
        bus0.rd_en = 1'b0;
        #1 chk("rst_ready_idle", bus0.ready, 1);
        chk("rst_read_data", bus0.read_data, 0);
        chk("rst_ctrl", {we0, oe0, ce0, ub0, lb0}, 5'b11000);
        chk("rst_addr", addr0, 0);
        chk("rst_ctrl1", {ce1, ub1, lb1}, 3'b000);
        next(1);
        rst = 1'b0;
        next(1);

        // Write, read back, write-wins collision
        issue0(1, 0, 32'd1032, 32'hDEADBEEF, 18'd4, 16'hBEEF, 16'hDEAD, 32'h0);
        issue0(0, 1, 32'd1032, 32'h0,        18'd4, 16'hBEEF, 16'hDEAD, 32'hDEADBEEF);
        issue0(1, 1, 32'd1024, 32'h12345678, 18'd0, 16'h5678, 16'h1234, 32'hDEADBEEF);

        // Back-to-back reads with the request held through DONE
        c0 = cyc;
        bus0.rd_en = 1'b1;
        bus0.address = 32'd1024;
        push_txn(0, 18'd0, 16'h5678, 16'h1234, 5, c0 + 5, 32'h12345678);
        push_txn(0, 18'd0, 16'h5678, 16'h1234, 5, c0 + 11, 32'h12345678);
        next(7);
        bus0.rd_en = 1'b0;
        next(5);

        issue0(1, 0, 32'd1040, 32'hCAFEF00D, 18'd8, 16'hF00D, 16'hCAFE, 32'h12345678);
        issue0(0, 1, 32'd1040, 32'h0,        18'd8, 16'hF00D, 16'hCAFE, 32'hCAFEF00D);

        // Reset during the high half of a write: only the low half lands
        c0 = cyc;
        bus0.wr_en = 1'b1;
        bus0.address = 32'd1048;
        bus0.write_data = 32'h0BADC0DE;
        push_txn(1, 18'd12, 16'hC0DE, 16'h0BAD, 3, c0 + 3, 32'h0);
        next(1);
        bus0.wr_en = 1'b0;
        bus0.address = 32'h0;
        bus0.write_data = 32'h0;
        next(2);
        #1 rst = 1'b1;
        next(2);
        rst = 1'b0;
        next(1);
        issue0(0, 1, 32'd1048, 32'h0, 18'd12, 16'hC0DE, 16'h0000, 32'h0000C0DE);

        // SRAM_WAIT = 1 variant
        issue1(1, 32'd1024, 32'h55AA33CC, 32'h0);
        issue1(0, 32'd1024, 32'h0,        32'h55AA33CC);
        issue1(0, 32'd1028, 32'h0,        32'h0);

        next(3);
        chk("beats_drained", beat_q.size(), 0);
        chk("dut0_done_drained", comp0_q.size(), 0);
        chk("dut1_done_drained", comp1_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
